// File: rtl/simple_isa_pkg.sv
// Shared ISA definitions for the writeback path: instruction classes, opcodes,
// phase bit indices and the writeback state/source encodings.
package simple_isa_pkg;

  localparam int unsigned WB_DATA_W  = 16;
  localparam int unsigned WB_REG_AW  = 3;
  localparam int unsigned WB_CMD_W   = 16;
  localparam int unsigned WB_PHASE_W = 5;

  localparam logic [1:0] CLS_ARITH = 2'b11;
  localparam logic [1:0] CLS_LD    = 2'b00;
  localparam logic [1:0] CLS_ST    = 2'b01;
  localparam logic [1:0] CLS_IMM   = 2'b10;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_CMP  = 4'b0101;
  localparam logic [3:0] OP_MOV  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SLR  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_IN   = 4'b1100;
  localparam logic [3:0] OP_OUT  = 4'b1101;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  localparam logic [2:0] OP2_LI   = 3'b000;
  localparam logic [2:0] OP2_ADDI = 3'b001;

  localparam int unsigned P1 = 0;
  localparam int unsigned P2 = 1;
  localparam int unsigned P3 = 2;
  localparam int unsigned P4 = 3;
  localparam int unsigned P5 = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECODED = 2'd1,
    ST_READY   = 2'd2,
    ST_HALTED  = 2'd3
  } wb_state_e;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MEM = 2'd1,
    SRC_IN  = 2'd2,
    SRC_IMM = 2'd3
  } src_sel_e;

endpackage

// File: rtl/wb_decode.sv
// Combinational writeback decode of the latched instruction: write enable,
// destination index, result source, halt flag and the sign-extended immediate.
module wb_decode
  import simple_isa_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W
) (
  input  logic [WB_CMD_W-1:0]  i_cmd,
  output logic                 o_we_c,
  output logic [WB_REG_AW-1:0] o_wr_idx_c,
  output src_sel_e             o_src_sel_c,
  output logic                 o_is_hlt_c,
  output logic [DATA_W-1:0]    o_imm_c
);

  logic [1:0] w_cls;
  logic [3:0] w_op;
  logic [2:0] w_op2;

  assign w_cls = i_cmd[15:14];
  assign w_op  = i_cmd[7:4];
  assign w_op2 = i_cmd[13:11];

  assign o_imm_c = {{(DATA_W-8){i_cmd[7]}}, i_cmd[7:0]};

  // No-write instructions still present wr=[10:8] and the ALU result
  always_comb begin
    o_we_c      = 1'b0;
    o_wr_idx_c  = i_cmd[10:8];
    o_src_sel_c = SRC_ALU;
    o_is_hlt_c  = 1'b0;
    case (w_cls)
      CLS_ARITH: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV,
          OP_SLL, OP_SLR, OP_SRL, OP_SRA: o_we_c = 1'b1;
          OP_IN: begin
            o_we_c      = 1'b1;
            o_src_sel_c = SRC_IN;
          end
          OP_HLT:  o_is_hlt_c = 1'b1;
          default: o_we_c     = 1'b0;
        endcase
      end
      CLS_LD: begin
        o_we_c      = 1'b1;
        o_wr_idx_c  = i_cmd[13:11];
        o_src_sel_c = SRC_MEM;
      end
      CLS_ST: o_we_c = 1'b0;
      CLS_IMM: begin
        case (w_op2)
          OP2_LI: begin
            o_we_c      = 1'b1;
            o_src_sel_c = SRC_IMM;
          end
          OP2_ADDI: o_we_c = 1'b1;
          default:  o_we_c = 1'b0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port producer: latches the instruction in p1, samples the
// result in p4 and presents RegWrite/wr/x through p5. Owns the sticky halt flag.
// Optional retired-write counter enabled by defining WB_STATS_EN.
module writeback_unit
  import simple_isa_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned REG_AW = WB_REG_AW
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WB_PHASE_W-1:0] phasecounter,
  input  logic [WB_CMD_W-1:0]   command,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  RegWrite,
  output logic [REG_AW-1:0]     wr,
  output logic [DATA_W-1:0]     x,
  output logic                  halt
`ifdef WB_STATS_EN
  ,
  output logic [DATA_W-1:0]     wb_count
`endif
);

  wb_state_e             r_state;
  wb_state_e             w_state_nxt;
  logic                  r_regwrite, w_regwrite_nxt;
  logic [REG_AW-1:0]     r_wr, w_wr_nxt;
  logic [DATA_W-1:0]     r_x, w_x_nxt;
  logic                  r_halt, w_halt_nxt;
  logic [WB_CMD_W-1:0]   r_cmd_q, w_cmd_nxt;

  logic                  w_we;
  logic [WB_REG_AW-1:0]  w_wr_idx;
  src_sel_e              w_src_sel;
  logic                  w_is_hlt;
  logic [DATA_W-1:0]     w_imm;
  logic [DATA_W-1:0]     w_result;
  logic                  w_p1, w_p4, w_p5;
  logic                  w_unused_phase;

  assign w_p1 = phasecounter[P1];
  assign w_p4 = phasecounter[P4];
  assign w_p5 = phasecounter[P5];
  assign w_unused_phase = ^phasecounter[P3:P2];

  wb_decode #(.DATA_W(DATA_W)) u_dec (
    .i_cmd       (r_cmd_q),
    .o_we_c      (w_we),
    .o_wr_idx_c  (w_wr_idx),
    .o_src_sel_c (w_src_sel),
    .o_is_hlt_c  (w_is_hlt),
    .o_imm_c     (w_imm)
  );

  always_comb begin
    case (w_src_sel)
      SRC_MEM: w_result = mem_rdata;
      SRC_IN:  w_result = in_data;
      SRC_IMM: w_result = w_imm;
      default: w_result = alu_result;
    endcase
  end

  // Next state and next output values; a p1 in DECODED/READY restarts decode
  always_comb begin
    w_state_nxt    = r_state;
    w_regwrite_nxt = r_regwrite;
    w_wr_nxt       = r_wr;
    w_x_nxt        = r_x;
    w_halt_nxt     = r_halt;
    w_cmd_nxt      = r_cmd_q;
    case (r_state)
      ST_IDLE: begin
        if (w_p1) begin
          w_cmd_nxt   = command;
          w_state_nxt = ST_DECODED;
        end
      end
      ST_DECODED: begin
        if (w_p1) begin
          w_regwrite_nxt = 1'b0;
          w_cmd_nxt      = command;
        end else if (w_p4) begin
          w_wr_nxt = REG_AW'(w_wr_idx);
          w_x_nxt  = w_result;
          if (w_is_hlt) begin
            w_regwrite_nxt = 1'b0;
            w_halt_nxt     = 1'b1;
            w_state_nxt    = ST_HALTED;
          end else begin
            w_regwrite_nxt = w_we;
            w_state_nxt    = ST_READY;
          end
        end
      end
      ST_READY: begin
        if (w_p1) begin
          w_regwrite_nxt = 1'b0;
          w_cmd_nxt      = command;
          w_state_nxt    = ST_DECODED;
        end else if (w_p5) begin
          w_regwrite_nxt = 1'b0;
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_HALTED: begin
        w_regwrite_nxt = 1'b0;
        w_halt_nxt     = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_regwrite <= 1'b0;
      r_wr       <= '0;
      r_x        <= '0;
      r_halt     <= 1'b0;
      r_cmd_q    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_regwrite <= w_regwrite_nxt;
      r_wr       <= w_wr_nxt;
      r_x        <= w_x_nxt;
      r_halt     <= w_halt_nxt;
      r_cmd_q    <= w_cmd_nxt;
    end
  end

  assign RegWrite = r_regwrite;
  assign wr       = r_wr;
  assign x        = r_x;
  assign halt     = r_halt;

`ifdef WB_STATS_EN
  logic [DATA_W-1:0] r_wb_count;
  logic              w_cnt_inc;

  // Counts each p4 edge that launches a write; wraps naturally
  assign w_cnt_inc = (r_state == ST_DECODED) && !w_p1 && w_p4 && w_we && !w_is_hlt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wb_count <= '0;
    end else if (w_cnt_inc) begin
      r_wb_count <= r_wb_count + DATA_W'(1);
    end
  end

  assign wb_count = r_wb_count;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed and randomized bench for writeback_unit against a table-driven
// reference of the writeback rules.
module tb_writeback_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  phasecounter;
  logic [15:0] command, alu_result, mem_rdata, in_data;
  logic        RegWrite;
  logic [2:0]  wr;
  logic [15:0] x;
  logic        halt;
`ifdef WB_STATS_EN
  logic [15:0] wb_count;
`endif

  always #5 clock = ~clock;

  writeback_unit dut (
    .clock        (clock),
    .reset        (reset),
    .phasecounter (phasecounter),
    .command      (command),
    .alu_result   (alu_result),
    .mem_rdata    (mem_rdata),
    .in_data      (in_data),
    .RegWrite     (RegWrite),
    .wr           (wr),
    .x            (x),
    .halt         (halt)
`ifdef WB_STATS_EN
    ,
    .wb_count     (wb_count)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state: what the register-file port should currently show
  logic [2:0]  m_wr;
  logic [15:0] m_x;
  bit          m_halted;
  bit          m_rw;
  logic [15:0] m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_wb(input logic [15:0] c, a, m, d,
                                 output bit we, output logic [2:0] w,
                                 output logic [15:0] v, output bit h);
    int op;
    int imm;
    we = 0; h = 0; w = c[10:8]; v = a;
    op = int'(c[7:4]);
    case (c[15:14])
      2'b11: begin
        if (op == 12) begin we = 1; v = d; end
        else if (op == 15) h = 1;
        else if (op <= 11 && op != 5 && op != 7) we = 1;
      end
      2'b00: begin we = 1; w = c[13:11]; v = m; end
      2'b10: begin
        if (c[13:11] == 3'd0) begin
          imm = $signed(c[7:0]);
          we = 1; v = 16'(imm);
        end else if (c[13:11] == 3'd1) we = 1;
      end
      default: we = 0;
    endcase
  endfunction

  task automatic check_port(input string tag);
    check({tag, "_rw"},   32'(RegWrite), 32'(m_rw));
    check({tag, "_wr"},   32'(wr),       32'(m_wr));
    check({tag, "_x"},    32'(x),        32'(m_x));
    check({tag, "_halt"}, 32'(halt),     32'(m_halted));
`ifdef WB_STATS_EN
    check({tag, "_cnt"},  32'(wb_count), 32'(m_count));
`endif
  endtask

  // p1..p4 of an instruction; ends at the negedge after the p4 edge
  task automatic front(input logic [15:0] c, a, m, d, input bit do_p1);
    bit we, h;
    logic [2:0] w;
    logic [15:0] v;
    if (do_p1) begin
      @(negedge clock);
      command = c;
      phasecounter = 5'b00001;
    end
    for (int p = 1; p < 4; p++) begin
      @(negedge clock);
      m_rw = 0;
      check("pre_p4_rw", 32'(RegWrite), 32'd0);
      phasecounter = 5'(1 << p);
      if (p == 3) begin
        alu_result = a; mem_rdata = m; in_data = d;
      end else begin
        alu_result = 16'($urandom); mem_rdata = 16'($urandom); in_data = 16'($urandom);
      end
    end
    @(negedge clock);
    ref_wb(c, a, m, d, we, w, v, h);
    if (!m_halted) begin
      m_wr = w; m_x = v; m_halted = h;
      m_rw = we && !h;
      if (m_rw) m_count++;
    end else begin
      m_rw = 0;
    end
    check_port("p5");
  endtask

  task automatic back();
    phasecounter = 5'b10000;
    @(negedge clock);
    m_rw = 0;
    check_port("after_p5");
    phasecounter = 5'b00000;
  endtask

  task automatic async_reset(input string tag);
    #1 reset = 1'b0;
    #1;
    m_wr = 0; m_x = 0; m_halted = 0; m_rw = 0; m_count = 0;
    check_port(tag);
    phasecounter = 5'b00000;
    #1 reset = 1'b1;
  endtask

  initial begin
    logic [15:0] c;
    reset = 1'b0; phasecounter = '0; command = '0;
    alu_result = '0; mem_rdata = '0; in_data = '0;
    m_wr = 0; m_x = 0; m_halted = 0; m_rw = 0; m_count = 0;
    #12;
    check_port("reset");
    @(negedge clock);
    reset = 1'b1;

    front(16'hD100, 16'h1234, 16'h0000, 16'h0000, 1); back();   // ADD r1
    front(16'h1D04, 16'h5555, 16'hBEEF, 16'h0000, 1); back();   // LD r3
    front(16'h86FE, 16'h7777, 16'h0000, 16'h0000, 1); back();   // LI r6, -2
    front(16'h8605, 16'h7777, 16'h0000, 16'h0000, 1); back();   // LI r6, 5
    front(16'hD150, 16'hAAAA, 16'h0000, 16'h0000, 1); back();   // CMP
    front(16'h5D04, 16'hBBBB, 16'hCCCC, 16'h0000, 1); back();   // ST
    front(16'hD1C0, 16'h0001, 16'h0002, 16'h4321, 1); back();   // IN r1
    front(16'h8832, 16'h0F0F, 16'h0000, 16'h0000, 1); back();   // ADDI

    // Reset while the write is being presented
    front(16'hD700, 16'h9999, 16'h0000, 16'h0000, 1);
    async_reset("reset_ready");

    // p1 injected while READY: write drops, new command decoded
    front(16'hD200, 16'h1111, 16'h0000, 16'h0000, 1);
    command = 16'h1804; phasecounter = 5'b00001;
    front(16'h1804, 16'h0000, 16'h2222, 16'h0000, 0); back();

    // p1 injected while DECODED: decode restarts with the newer command
    @(negedge clock); command = 16'hD300; phasecounter = 5'b00001;
    @(negedge clock); phasecounter = 5'b00010;
    @(negedge clock); command = 16'h85F0; phasecounter = 5'b00001;
    front(16'h85F0, 16'h3333, 16'h0000, 16'h0000, 0); back();

    // Randomized instruction stream, halt excluded
    for (int i = 0; i < 150; i++) begin
      c = 16'($urandom);
      if (c[15:14] == 2'b11 && c[7:4] == 4'hF) c[7:4] = 4'(i % 15);
      front(c, 16'($urandom), 16'($urandom), 16'($urandom), 1);
      back();
    end

    // Halt is sticky: later instructions never write
    front(16'hC0F0, 16'h4444, 16'h0000, 16'h0000, 1); back();
    front(16'hD100, 16'h5678, 16'h0000, 16'h0000, 1); back();
    @(negedge clock);
    async_reset("reset_halted");
    front(16'hD100, 16'h2468, 16'h0000, 16'h0000, 1); back();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
